// File: rtl/ita_output_buffer.sv
// ita_output_buffer: staging FIFO between requantization and the ITA output
// stream. Pushes are unconditional (no backpressure upstream); padded lanes
// are zeroed on write; popped beats are counted to tag tile boundaries.
module ita_output_buffer #(
    parameter int unsigned N     = 16,
    parameter int unsigned WO    = 8,
    parameter int unsigned M     = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         data_valid_i,
    input  logic [N*WO-1:0]              data_i,
    input  logic [N-1:0]                 pad_mask_i,
    output logic [N*WO-1:0]              oup_data_o,
    output logic                         oup_valid_o,
    input  logic                         oup_ready_i,
    output logic                         oup_last_o,
    output logic                         tile_done_o,
    output logic [$clog2(DEPTH+1)-1:0]   fill_o,
    output logic                         overflow_o
);

    localparam int unsigned TILE_BEATS = M * M / N;
    localparam int unsigned CW         = (TILE_BEATS > 1) ? $clog2(TILE_BEATS) : 1;
    localparam int unsigned PW         = $clog2(DEPTH);
    localparam int unsigned FW         = $clog2(DEPTH + 1);

    // Occupancy view derived from fill; there is no separate state register.
    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_e;

    occ_e              occ;
    logic [N*WO-1:0]   mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [FW-1:0]     fill_q;
    logic [CW-1:0]     beat_cnt_q;
    logic              tile_done_q;
    logic              overflow_q;
    logic [N*WO-1:0]   masked;
    logic              push;
    logic              pop;

    // Classify occupancy from the registered fill level.
    always_comb begin
        occ = PARTIAL;
        if (fill_q == '0) begin
            occ = EMPTY;
        end else if (fill_q == FW'(DEPTH)) begin
            occ = FULL;
        end
    end

    // Zero every lane flagged as padding before it is stored.
    always_comb begin
        masked = data_i;
        for (int unsigned i = 0; i < N; i++) begin
            if (pad_mask_i[i]) begin
                masked[i*WO +: WO] = '0;
            end
        end
    end

    assign oup_valid_o = (occ != EMPTY);
    assign oup_data_o  = mem_q[rd_ptr_q];
    assign oup_last_o  = oup_valid_o && (beat_cnt_q == CW'(TILE_BEATS - 1));
    assign pop         = oup_valid_o && oup_ready_i;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign push        = data_valid_i && ((occ != FULL) || pop);

    assign fill_o      = fill_q;
    assign overflow_o  = overflow_q;
    assign tile_done_o = tile_done_q;

    // Pointers, fill level, tile beat counter and status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            beat_cnt_q  <= '0;
            tile_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (clear_i) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            beat_cnt_q  <= '0;
            tile_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                if (oup_last_o) begin
                    beat_cnt_q <= '0;
                end else begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                end
            end
            if (push && !pop) begin
                fill_q <= fill_q + 1'b1;
            end else if (pop && !push) begin
                fill_q <= fill_q - 1'b1;
            end
            if (data_valid_i && (occ == FULL) && !pop) begin
                overflow_q <= 1'b1;
            end
            tile_done_q <= pop && oup_last_o;
        end
    end

    // Beat storage; reset to zero so the idle head reads zero, but a flush leaves it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !clear_i) begin
            mem_q[wr_ptr_q] <= masked;
        end
    end

endmodule

// File: tb/tb_ita_output_buffer.sv
// tb_ita_output_buffer: directed stimulus with a scoreboard queue; a negedge
// monitor compares every presented head beat against the queue.
module tb_ita_output_buffer;

    localparam int unsigned N     = 16;
    localparam int unsigned WO    = 8;
    localparam int unsigned M     = 64;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = N * WO;
    localparam int unsigned FW    = $clog2(DEPTH + 1);
    localparam int unsigned TB    = M * M / N;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          data_valid_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic [N-1:0]  pad_mask_i = '0;
    logic [DW-1:0] oup_data_o;
    logic          oup_valid_o;
    logic          oup_ready_i = 1'b0;
    logic          oup_last_o;
    logic          tile_done_o;
    logic [FW-1:0] fill_o;
    logic          overflow_o;

    exp_t          sb[$];
    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    int unsigned   exp_pos = 0;
    int unsigned   tile_pulses = 0;
    int unsigned   max_fill = 0;
    bit            prev_lastpop = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit            bp_done = 1'b0;

    ita_output_buffer #(.N(N), .WO(WO), .M(M), .DEPTH(DEPTH)) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .data_valid_i(data_valid_i),
        .data_i      (data_i),
        .pad_mask_i  (pad_mask_i),
        .oup_data_o  (oup_data_o),
        .oup_valid_o (oup_valid_o),
        .oup_ready_i (oup_ready_i),
        .oup_last_o  (oup_last_o),
        .tile_done_o (tile_done_o),
        .fill_o      (fill_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] make_beat(input int unsigned k);
        logic [DW-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            b[i*WO +: WO] = WO'(k + i);
        end
        return b;
    endfunction

    function automatic logic [DW-1:0] splat(input logic [WO-1:0] v);
        return {N{v}};
    endfunction

    // Drive one beat for one edge; record it if the FIFO is expected to take it.
    task automatic push_beat(input logic [DW-1:0] d, input logic [N-1:0] m,
                             input logic [DW-1:0] exp_d, input bit accept);
        data_valid_i = 1'b1;
        data_i       = d;
        pad_mask_i   = m;
        @(posedge clk_i);
        #1;
        data_valid_i = 1'b0;
        pad_mask_i   = '0;
        if (accept) begin
            sb.push_back('{data: exp_d, last: (exp_pos == TB - 1)});
            exp_pos = (exp_pos + 1) % TB;
        end
    endtask

    task automatic drain();
        int unsigned t;
        t = 0;
        while (sb.size() != 0 && t < 4000) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        chk("drain_empty", DW'(sb.size()), '0);
        repeat (2) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        sb.delete();
        exp_pos = 0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", DW'(oup_valid_o), '0);
        chk("async_rst_fill", DW'(fill_o), '0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        sb.delete();
        exp_pos = 0;
    endtask

    // Monitor: compare head beat/last flag, head stability and tile_done timing.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_lastpop = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            if (tile_done_o) tile_pulses++;
            if (tile_done_o || prev_lastpop) begin
                chk("tile_done", DW'(tile_done_o), DW'(prev_lastpop));
            end
            if (prev_stall) begin
                chk("stall_valid", DW'(oup_valid_o), DW'(1));
                chk("stall_head", oup_data_o, prev_data);
            end
            if (int'(fill_o) > int'(max_fill)) max_fill = fill_o;
            prev_lastpop = 1'b0;
            if (oup_valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", oup_data_o, 'x);
                end else begin
                    chk("head_data", oup_data_o, sb[0].data);
                    chk("head_last", DW'(oup_last_o), DW'(sb[0].last));
                    if (oup_ready_i && !clear_i) begin
                        prev_lastpop = sb[0].last;
                        void'(sb.pop_front());
                    end
                end
            end
            prev_stall = oup_valid_o && !oup_ready_i && !clear_i;
            prev_data  = oup_data_o;
        end
    end

    initial begin
        #100000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned pulses0;
        int unsigned g;
        // Reset values.
        #2;
        chk("rst_valid", DW'(oup_valid_o), '0);
        chk("rst_last", DW'(oup_last_o), '0);
        chk("rst_tile_done", DW'(tile_done_o), '0);
        chk("rst_fill", DW'(fill_o), '0);
        chk("rst_overflow", DW'(overflow_o), '0);
        chk("rst_data", oup_data_o, '0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Streaming, ready held high: 1-cycle latency, last only on beat 255.
        oup_ready_i = 1'b1;
        max_fill = 0;
        pulses0 = tile_pulses;
        data_valid_i = 1'b1;
        data_i = make_beat(0);
        #1;
        chk("no_bypass", DW'(oup_valid_o), '0);
        push_beat(make_beat(0), '0, make_beat(0), 1'b1);
        chk("latency_valid", DW'(oup_valid_o), DW'(1));
        chk("latency_data", oup_data_o, make_beat(0));
        for (int unsigned k = 1; k < TB; k++) begin
            push_beat(make_beat(k), '0, make_beat(k), 1'b1);
        end
        drain();
        chk("stream_tile_pulses", DW'(tile_pulses - pulses0), DW'(1));
        chk("stream_max_fill", DW'(max_fill), DW'(1));

        // Padding: top four lanes masked.
        oup_ready_i = 1'b0;
        do_clear();
        push_beat(splat(8'h7F), 16'hF000, 128'h00000000_7F7F7F7F_7F7F7F7F_7F7F7F7F, 1'b1);
        chk("pad_data", oup_data_o, 128'h00000000_7F7F7F7F_7F7F7F7F_7F7F7F7F);
        oup_ready_i = 1'b1;
        drain();

        // Full and overflow: beat 9 dropped, flag sticky until clear.
        oup_ready_i = 1'b0;
        for (int unsigned k = 1; k <= 9; k++) begin
            push_beat(splat(WO'(k)), '0, splat(WO'(k)), k <= DEPTH);
        end
        chk("full_fill", DW'(fill_o), DW'(DEPTH));
        chk("full_overflow", DW'(overflow_o), DW'(1));
        oup_ready_i = 1'b1;
        drain();
        chk("overflow_sticky", DW'(overflow_o), DW'(1));
        chk("drained_fill", DW'(fill_o), '0);
        oup_ready_i = 1'b0;
        do_clear();
        chk("clear_overflow", DW'(overflow_o), '0);

        // Full with simultaneous push and pop.
        for (int unsigned k = 0; k < DEPTH; k++) begin
            push_beat(splat(WO'(8'h11 + k)), '0, splat(WO'(8'h11 + k)), 1'b1);
        end
        chk("fwp_fill_before", DW'(fill_o), DW'(DEPTH));
        oup_ready_i = 1'b1;
        push_beat(splat(8'hAA), '0, splat(8'hAA), 1'b1);
        oup_ready_i = 1'b0;
        chk("fwp_fill_after", DW'(fill_o), DW'(DEPTH));
        chk("fwp_overflow", DW'(overflow_o), '0);
        chk("fwp_head", oup_data_o, splat(8'h12));
        oup_ready_i = 1'b1;
        drain();

        // Backpressure: random ready over 512 beats.
        oup_ready_i = 1'b0;
        do_clear();
        pulses0 = tile_pulses;
        bp_done = 1'b0;
        fork
            begin
                for (int unsigned k = 0; k < 2 * TB; k++) begin
                    g = 0;
                    while (fill_o == FW'(DEPTH) && g < 1000) begin
                        @(posedge clk_i);
                        #1;
                        g++;
                    end
                    push_beat(make_beat(k * 3), '0, make_beat(k * 3), 1'b1);
                end
                drain();
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk_i);
                    #1;
                    oup_ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        chk("bp_tile_pulses", DW'(tile_pulses - pulses0), DW'(2));

        // Clear mid-tile, then a fresh tile.
        for (int pass = 0; pass < 2; pass++) begin
            oup_ready_i = 1'b0;
            do_clear();
            oup_ready_i = 1'b1;
            for (int unsigned k = 0; k < 100; k++) begin
                push_beat(make_beat(k + 7), '0, make_beat(k + 7), 1'b1);
            end
            drain();
            oup_ready_i = 1'b0;
            for (int unsigned k = 0; k < 3; k++) begin
                push_beat(make_beat(k + 50), '0, make_beat(k + 50), 1'b1);
            end
            if (pass == 0) begin
                do_clear();
            end else begin
                do_reset();
            end
            chk("flush_fill", DW'(fill_o), '0);
            chk("flush_valid", DW'(oup_valid_o), '0);
            pulses0 = tile_pulses;
            oup_ready_i = 1'b1;
            for (int unsigned k = 0; k < TB; k++) begin
                push_beat(make_beat(k + 1), '0, make_beat(k + 1), 1'b1);
            end
            drain();
            chk("flush_tile_pulses", DW'(tile_pulses - pulses0), DW'(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
